// File: rtl/exchange_sched.sv
// Replica exchange sweep sequencer. For each slot it decides, issues, reads, and tracks the write-back.
// Optional macro EXCHANGE_OVERLAP_EN lets the next issue overlap the previous slot's outstanding writes.
package exchange_sched_pkg;
    typedef enum logic [1:0] {
        NOP  = 2'd0,
        PREV = 2'd1,
        FOLW = 2'd2,
        SELF = 2'd3
    } exchange_command_t;
    typedef logic [1:0] opt_t;
endpackage

module exchange_sched
    import exchange_sched_pkg::*;
#(
    parameter int city_div     = 8,
    parameter int city_div_log = 3,
    parameter int base_num     = 4,
    parameter int base_log     = 2,
    parameter int issue_gap    = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                dec_req,
    output logic [base_log-1:0] dec_base_id,
    input  logic                dec_ack,
    input  exchange_command_t   dec_cmd,
    input  opt_t                dec_opt,
    output exchange_command_t   command,
    output opt_t                opt,
    output logic [base_log-1:0] ex_base_id_r,
    output logic [base_log-1:0] ex_base_id_w,
    input  logic                wr_beat,
    output logic                wr_err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECIDE = 3'd1,
        ISSUE  = 3'd2,
        READ   = 3'd3,
        GAP    = 3'd4,
        DRAIN  = 3'd5
    } state_t;

    // issue_gap is expected to be at least 1
    localparam int GAP_W = (issue_gap > 1) ? $clog2(issue_gap) : 1;
    localparam logic [city_div_log-1:0] BEAT_LAST = city_div_log'(city_div - 1);
    localparam logic [GAP_W-1:0]        GCNT_LAST = GAP_W'(issue_gap - 1);
    localparam logic [base_log-1:0]     SLOT_LAST = base_log'(base_num - 1);

    // A NOP slot is copied in place so every slot produces exactly one write burst
    function automatic exchange_command_t remap_cmd(input exchange_command_t c);
        remap_cmd = (c == NOP) ? SELF : c;
    endfunction

    state_t                  state_r, state_s;
    logic [base_log-1:0]     slot_r, slot_s;
    logic [city_div_log-1:0] rcnt_r, rcnt_s;
    logic [GAP_W-1:0]        gcnt_r, gcnt_s;
    exchange_command_t       cap_cmd_r, cap_cmd_s;
    opt_t                    cap_opt_r, cap_opt_s;
    logic                    cap_vld_r, cap_vld_s;
    logic                    busy_r, busy_s, done_r, done_s, dec_req_r, dec_req_s;
    logic [base_log-1:0]     dec_id_r, dec_id_s, id_rd_r, id_rd_s;
    exchange_command_t       command_r, command_s;
    opt_t                    opt_r, opt_s;
    logic [base_log-1:0]     head_r, head_s, tail_r, tail_s;
    logic [1:0]              fcnt_r, fcnt_s;
    logic [city_div_log-1:0] wcnt_r, wcnt_s;
    logic                    wr_err_r, wr_err_s;
    logic                    push_s, beat_ok_s, pop_s, push_full_s, gap_ok_s;

    assign push_s      = (state_r == ISSUE);
    assign beat_ok_s   = wr_beat && (fcnt_r != 2'd0);
    assign pop_s       = beat_ok_s && (wcnt_r == BEAT_LAST);
    assign push_full_s = push_s && !pop_s && (fcnt_r == 2'd2);

`ifdef EXCHANGE_OVERLAP_EN
    assign gap_ok_s = 1'b1;
`else
    assign gap_ok_s = (fcnt_r == 2'd0);
`endif

    // Outstanding-write FIFO; the head register is the write-side slot id
    always_comb begin
        head_s   = head_r;
        tail_s   = tail_r;
        fcnt_s   = fcnt_r;
        wcnt_s   = wcnt_r;
        wr_err_s = wr_err_r | (wr_beat && (fcnt_r == 2'd0)) | push_full_s;
        if (beat_ok_s) begin
            wcnt_s = pop_s ? {city_div_log{1'b0}} : wcnt_r + city_div_log'(1);
        end else begin
            wcnt_s = wcnt_r;
        end
        case ({push_s, pop_s})
            2'b10: begin
                if (fcnt_r == 2'd0) begin
                    head_s = slot_r;
                    fcnt_s = 2'd1;
                end else if (fcnt_r == 2'd1) begin
                    tail_s = slot_r;
                    fcnt_s = 2'd2;
                end else begin
                    fcnt_s = fcnt_r;
                end
            end
            2'b01: begin
                head_s = (fcnt_r == 2'd2) ? tail_r : head_r;
                fcnt_s = fcnt_r - 2'd1;
            end
            2'b11: begin
                if (fcnt_r == 2'd1) begin
                    head_s = slot_r;
                end else begin
                    head_s = tail_r;
                    tail_s = slot_r;
                end
            end
            default: begin
                fcnt_s = fcnt_r;
            end
        endcase
    end

    // Sweep FSM: next state and next values of the registered outputs
    always_comb begin
        state_s   = state_r;
        slot_s    = slot_r;
        rcnt_s    = rcnt_r;
        gcnt_s    = gcnt_r;
        cap_cmd_s = cap_cmd_r;
        cap_opt_s = cap_opt_r;
        cap_vld_s = cap_vld_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        dec_req_s = dec_req_r;
        dec_id_s  = dec_id_r;
        id_rd_s   = id_rd_r;
        command_s = NOP;
        opt_s     = opt_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    slot_s    = {base_log{1'b0}};
                    busy_s    = 1'b1;
                    dec_req_s = 1'b1;
                    dec_id_s  = {base_log{1'b0}};
                    cap_vld_s = 1'b0;
                    state_s   = DECIDE;
                end else begin
                    state_s = IDLE;
                end
            end
            DECIDE: begin
                if (cap_vld_r && (fcnt_r != 2'd2)) begin
                    command_s = cap_cmd_r;
                    opt_s     = cap_opt_r;
                    id_rd_s   = slot_r;
                    cap_vld_s = 1'b0;
                    state_s   = ISSUE;
                end else if (!cap_vld_r && dec_ack) begin
                    // A full FIFO parks the captured decision with dec_req dropped
                    cap_cmd_s = remap_cmd(dec_cmd);
                    cap_opt_s = dec_opt;
                    dec_req_s = 1'b0;
                    if (fcnt_r == 2'd2) begin
                        cap_vld_s = 1'b1;
                    end else begin
                        command_s = remap_cmd(dec_cmd);
                        opt_s     = dec_opt;
                        id_rd_s   = slot_r;
                        state_s   = ISSUE;
                    end
                end else begin
                    state_s = DECIDE;
                end
            end
            ISSUE: begin
                rcnt_s  = {city_div_log{1'b0}};
                state_s = READ;
            end
            READ: begin
                if (rcnt_r == BEAT_LAST) begin
                    rcnt_s = {city_div_log{1'b0}};
                    if (slot_r == SLOT_LAST) begin
                        state_s = DRAIN;
                    end else begin
                        slot_s  = slot_r + base_log'(1);
                        gcnt_s  = {GAP_W{1'b0}};
                        state_s = GAP;
                    end
                end else begin
                    rcnt_s = rcnt_r + city_div_log'(1);
                end
            end
            GAP: begin
                if ((gcnt_r == GCNT_LAST) && gap_ok_s) begin
                    dec_req_s = 1'b1;
                    dec_id_s  = slot_r;
                    state_s   = DECIDE;
                end else if (gcnt_r != GCNT_LAST) begin
                    gcnt_s = gcnt_r + GAP_W'(1);
                end else begin
                    gcnt_s = gcnt_r;
                end
            end
            DRAIN: begin
                if (fcnt_s == 2'd0) begin
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counters, FIFO and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            slot_r    <= {base_log{1'b0}};
            rcnt_r    <= {city_div_log{1'b0}};
            gcnt_r    <= {GAP_W{1'b0}};
            cap_cmd_r <= NOP;
            cap_opt_r <= 2'd0;
            cap_vld_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            dec_req_r <= 1'b0;
            dec_id_r  <= {base_log{1'b0}};
            id_rd_r   <= {base_log{1'b0}};
            command_r <= NOP;
            opt_r     <= 2'd0;
            head_r    <= {base_log{1'b0}};
            tail_r    <= {base_log{1'b0}};
            fcnt_r    <= 2'd0;
            wcnt_r    <= {city_div_log{1'b0}};
            wr_err_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            slot_r    <= slot_s;
            rcnt_r    <= rcnt_s;
            gcnt_r    <= gcnt_s;
            cap_cmd_r <= cap_cmd_s;
            cap_opt_r <= cap_opt_s;
            cap_vld_r <= cap_vld_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            dec_req_r <= dec_req_s;
            dec_id_r  <= dec_id_s;
            id_rd_r   <= id_rd_s;
            command_r <= command_s;
            opt_r     <= opt_s;
            head_r    <= head_s;
            tail_r    <= tail_s;
            fcnt_r    <= fcnt_s;
            wcnt_r    <= wcnt_s;
            wr_err_r  <= wr_err_s;
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign dec_req      = dec_req_r;
    assign dec_base_id  = dec_id_r;
    assign command      = command_r;
    assign opt          = opt_r;
    assign ex_base_id_r = id_rd_r;
    assign ex_base_id_w = head_r;
    assign wr_err       = wr_err_r;

endmodule

// File: tb/tb_exchange_sched.sv
// Directed bench for exchange_sched: sweeps with various ack/write-back timings, reset and error cases.
// Expected spacings depend on EXCHANGE_OVERLAP_EN, matching the build of the design.
module tb_exchange_sched;
    import exchange_sched_pkg::*;

`ifdef EXCHANGE_OVERLAP_EN
    localparam int SP_A = 11;
    localparam int SP_C = 11;
    localparam int W_C  = 0;
`else
    localparam int SP_A = 14;
    localparam int SP_C = 22;
    localparam int W_C  = 1;
`endif

    logic              clk, reset, start, busy, done, dec_req, dec_ack, wr_beat, wr_err;
    logic [1:0]        dec_base_id, ex_base_id_r, ex_base_id_w;
    exchange_command_t dec_cmd, command;
    opt_t              dec_opt, opt;

    exchange_sched dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .dec_req(dec_req), .dec_base_id(dec_base_id), .dec_ack(dec_ack),
        .dec_cmd(dec_cmd), .dec_opt(dec_opt), .command(command), .opt(opt),
        .ex_base_id_r(ex_base_id_r), .ex_base_id_w(ex_base_id_w),
        .wr_beat(wr_beat), .wr_err(wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int beat_delay = 4;
    logic [63:0] sched = 64'd0;
    exchange_command_t cmd_tab [4] = '{PREV, FOLW, SELF, NOP};
    exchange_command_t exp_cmd [4] = '{PREV, FOLW, SELF, SELF};
    opt_t opt_tab [4] = '{2'd1, 2'd2, 2'd3, 2'd2};
    int ack_dly [4] = '{0, 0, 0, 0};
    exchange_command_t iss_cmd [16];
    opt_t iss_opt [16];
    logic [1:0] iss_id [16];
    int iss_cyc [16];
    int n_iss, n_beats, done_cnt, done_cyc, req2_cnt, req_age, s_cyc;
    logic prev_req = 1'b0;
    logic [1:0] w_log [64];
    logic [1:0] w_hist [4096];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs after the edge, log events, and drive the responders
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        sched = sched >> 1;
        if (command != NOP && n_iss < 16) begin
            iss_cmd[n_iss] = command;
            iss_opt[n_iss] = opt;
            iss_id[n_iss]  = ex_base_id_r;
            iss_cyc[n_iss] = cyc;
            n_iss++;
            sched = sched | (64'hFF << beat_delay);
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (dec_req === 1'b1 && dec_base_id === 2'd2) req2_cnt++;
        req_age  = (dec_req === 1'b1 && prev_req === 1'b1) ? req_age + 1 : 0;
        prev_req = dec_req;
        w_hist[cyc % 4096] = ex_base_id_w;
        wr_beat = sched[0];
        if (wr_beat && n_beats < 64) begin
            w_log[n_beats] = ex_base_id_w;
            n_beats++;
        end
        dec_cmd = cmd_tab[dec_base_id];
        dec_opt = opt_tab[dec_base_id];
        dec_ack = (dec_req === 1'b1) ? (req_age >= ack_dly[dec_base_id]) : 1'b1;
    endtask

    task automatic clear_log();
        n_iss = 0; n_beats = 0; done_cnt = 0; done_cyc = 0; req2_cnt = 0;
    endtask

    task automatic wait_issues(input int n, input int limit);
        for (int i = 0; i < limit && n_iss < n; i++) tick();
        check("issue_timeout", n_iss >= n, 1);
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit && done_cnt == 0; i++) tick();
        check("done_timeout", done_cnt >= 1, 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        s_cyc = cyc;
        tick();
        start = 1'b0;
        check("start_dec_req", dec_req, 1);
        check("start_dec_id", dec_base_id, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; wr_beat = 1'b0; dec_ack = 1'b0;
        dec_cmd = NOP; dec_opt = 2'd0; req_age = 0;
        clear_log();
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dec_req", dec_req, 0);
        check("rst_wr_err", wr_err, 0);
        check("rst_command", command, NOP);
        check("rst_opt", opt, 0);
        check("rst_id_r", ex_base_id_r, 0);
        check("rst_id_w", ex_base_id_w, 0);
        check("rst_dec_id", dec_base_id, 0);
        reset = 1'b0;
        tick();

        // Sweep A: immediate acks, writes 4 cycles after issue, start re-pulsed mid-sweep
        beat_delay = 4;
        clear_log();
        pulse_start();
        wait_issues(1, 50);
        tick(); tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(300);
        repeat (20) tick();
        check("A_first_issue_cyc", iss_cyc[0], s_cyc + 2);
        check("A_issues", n_iss, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("A_cmd%0d", i), iss_cmd[i], exp_cmd[i]);
            check($sformatf("A_opt%0d", i), iss_opt[i], opt_tab[i]);
            check($sformatf("A_id_r%0d", i), iss_id[i], i);
            if (i > 0) check($sformatf("A_spacing%0d", i), iss_cyc[i] - iss_cyc[i-1], SP_A);
        end
        check("A_beats", n_beats, 32);
        for (int b = 0; b < 32; b++) check($sformatf("A_id_w_beat%0d", b), w_log[b], b / 8);
        check("A_done_cnt", done_cnt, 1);
        check("A_done_cyc", done_cyc, iss_cyc[3] + 12);
        check("A_busy_end", busy, 0);
        check("A_wr_err", wr_err, 0);

        // Sweep B: decision for slot 2 acknowledged 5 cycles late
        ack_dly[2] = 5;
        clear_log();
        pulse_start();
        wait_done(300);
        repeat (5) tick();
        ack_dly[2] = 0;
        check("B_issues", n_iss, 4);
        check("B_spacing1", iss_cyc[1] - iss_cyc[0], SP_A);
        check("B_spacing2", iss_cyc[2] - iss_cyc[1], SP_A + 5);
        check("B_spacing3", iss_cyc[3] - iss_cyc[2], SP_A);
        check("B_req2_cycles", req2_cnt, 6);
        check("B_id_r2", iss_id[2], 2);
        check("B_done_cnt", done_cnt, 1);

        // Sweep C: write-back delayed 12 cycles after issue
        beat_delay = 12;
        clear_log();
        pulse_start();
        wait_done(400);
        repeat (5) tick();
        check("C_issues", n_iss, 4);
        for (int i = 1; i < 4; i++) check($sformatf("C_spacing%0d", i), iss_cyc[i] - iss_cyc[i-1], SP_C);
        check("C_id_w_after_issue1", w_hist[(iss_cyc[1] + 1) % 4096], W_C);
        check("C_beats", n_beats, 32);
        for (int b = 0; b < 32; b += 4) check($sformatf("C_id_w_beat%0d", b), w_log[b], b / 8);
        check("C_done_cyc", done_cyc, iss_cyc[3] + 20);
        check("C_wr_err", wr_err, 0);

        // Reset in the middle of slot 1's read phase
        beat_delay = 4;
        clear_log();
        pulse_start();
        wait_issues(2, 100);
        tick(); tick(); tick();
        check("R_busy_before", busy, 1);
        reset = 1'b1;
        sched = 64'd0;
        wr_beat = 1'b0;
        tick();
        reset = 1'b0;
        check("R_busy", busy, 0);
        check("R_command", command, NOP);
        check("R_id_r", ex_base_id_r, 0);
        check("R_id_w", ex_base_id_w, 0);
        check("R_dec_id", dec_base_id, 0);
        check("R_dec_req", dec_req, 0);
        check("R_done", done, 0);
        repeat (30) tick();
        check("R_no_done", done_cnt, 0);
        clear_log();
        pulse_start();
        wait_done(300);
        check("R2_first_id_r", iss_id[0], 0);
        check("R2_issues", n_iss, 4);
        check("R2_done_cnt", done_cnt, 1);
        check("R2_wr_err", wr_err, 0);

        // Stray write beat while idle is a sticky protocol error
        repeat (3) tick();
        check("E_idle", busy, 0);
        wr_beat = 1'b1;
        tick();
        check("E_wr_err_set", wr_err, 1);
        repeat (5) tick();
        check("E_wr_err_sticky", wr_err, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("E_wr_err_cleared", wr_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
